// File: rtl/hack_data_memory.sv
// Hack data memory responder: 16K RAM, FIFO-buffered screen writes, latched keyboard.
// Optional macro HACK_SCREEN_SHADOW_EN adds an 8K screen shadow RAM that makes screen words readable.
module hack_data_memory #(
  parameter int FIFO_DEPTH = 8,
  parameter int RAM_WORDS  = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_strobe,
  input  logic        kbd_release,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [12:0] fb_addr,
  output logic [15:0] fb_data,
  output logic        fb_overflow
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_SCR, SEL_KBD} sel_t;

  logic w_is_ram, w_is_scr, w_is_kbd;
  assign w_is_ram = (addressM[14] == 1'b0);
  assign w_is_scr = (addressM[14:13] == 2'b10);
  assign w_is_kbd = (addressM == 15'h6000);

  // Writes sampled during reset are ignored on every path.
  logic w_wr_ok;
  assign w_wr_ok = writeM && !reset;

  // General RAM: plain array with registered, read-first output.
  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_ram_q;
  always_ff @(posedge clk) begin
    if (w_wr_ok && w_is_ram) r_ram[addressM[RAW-1:0]] <= outM;
    r_ram_q <= r_ram[addressM[RAW-1:0]];
  end

  logic [15:0] w_scr_q;
`ifdef HACK_SCREEN_SHADOW_EN
  logic [15:0] r_shadow [8192];
  logic [15:0] r_shadow_q;
  always_ff @(posedge clk) begin
    if (w_wr_ok && w_is_scr) r_shadow[addressM[12:0]] <= outM;
    r_shadow_q <= r_shadow[addressM[12:0]];
  end
  assign w_scr_q = r_shadow_q;
`else
  assign w_scr_q = 16'h0000;
`endif

  // Keyboard latch: strobe has priority over release.
  logic [15:0] r_key;
  logic [15:0] r_key_q;
  always_ff @(posedge clk) begin
    if (reset)            r_key <= 16'h0000;
    else if (kbd_strobe)  r_key <= kbd_code;
    else if (kbd_release) r_key <= 16'h0000;
    r_key_q <= r_key;
  end

  // Region of the address presented last cycle selects which registered word drives inM.
  sel_t r_sel;
  always_ff @(posedge clk) begin
    if (reset)         r_sel <= SEL_ZERO;
    else if (w_is_ram) r_sel <= SEL_RAM;
    else if (w_is_scr) r_sel <= SEL_SCR;
    else if (w_is_kbd) r_sel <= SEL_KBD;
    else               r_sel <= SEL_ZERO;
  end

  always_comb begin
    inM = 16'h0000;
    case (r_sel)
      SEL_RAM: inM = r_ram_q;
      SEL_SCR: inM = w_scr_q;
      SEL_KBD: inM = r_key_q;
      default: inM = 16'h0000;
    endcase
  end

  // Screen write FIFO; head is presented straight from storage, gated by valid.
  logic [28:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;

  logic w_push, w_pop, w_full, w_accept, w_drop;
  assign w_push   = w_wr_ok && w_is_scr;
  assign w_pop    = (r_count != '0) && fb_ready;
  assign w_full   = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_accept) r_fifo[r_wr_ptr] <= {addressM[12:0], outM};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  logic [28:0] w_head;
  assign w_head      = r_fifo[r_rd_ptr];
  assign fb_valid    = (r_count != '0);
  assign fb_addr     = fb_valid ? w_head[28:16] : 13'h0000;
  assign fb_data     = fb_valid ? w_head[15:0]  : 16'h0000;
  assign fb_overflow = r_overflow;

endmodule
